// File: rtl/pow_sched.sv
// Round-robin front end that shares one pow32 square-and-multiply engine
// among N requesters, with a watchdog that aborts and resets a hung engine.
module pow_sched #(
  parameter int N       = 4,
  parameter int TIMEOUT = 128
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N-1:0]           req_valid,
  output logic [N-1:0]           req_ready,
  input  logic [32*N-1:0]        req_x,
  input  logic [32*N-1:0]        req_e,
  output logic [N-1:0]           rsp_valid,
  input  logic [N-1:0]           rsp_ready,
  output logic [31:0]            rsp_y,
  output logic                   rsp_err,
  output logic                   busy,
  output logic [$clog2(N)-1:0]   grant_id,
  output logic                   eng_rst_n,
  output logic                   eng_ld,
  output logic [31:0]            eng_x,
  output logic [31:0]            eng_e,
  input  logic                   eng_done,
  input  logic [31:0]            eng_y
);

  localparam int IDW    = $clog2(N);
  localparam int DATA_W = 32;
  localparam int TW     = $clog2(TIMEOUT);

  typedef enum logic [2:0] {IDLE, LOAD, RUN, ABORT, RESP} state_t;

  state_t            state, state_nxt;
  logic [IDW-1:0]    last;
  logic [IDW-1:0]    gnt;
  logic [IDW-1:0]    idx;
  logic              hit;
  logic [N-1:0]      gnt_oh;
  logic [N-1:0]      rsp_oh;
  logic [TW-1:0]     timer;
  logic [DATA_W-1:0] op_x, op_e;
  logic [DATA_W-1:0] sel_x, sel_e;

  // Rotating-priority search: first asserted req_valid after the last winner.
  always_comb begin
    hit = 1'b0;
    gnt = '0;
    idx = '0;
    for (int i = 0; i < N; i++) begin
      idx = IDW'((int'(last) + 1 + i) % N);
      if (!hit && req_valid[idx]) begin
        hit = 1'b1;
        gnt = idx;
      end
    end
  end

  always_comb begin
    gnt_oh = '0;
    rsp_oh = '0;
    sel_x  = '0;
    sel_e  = '0;
    gnt_oh[gnt]      = 1'b1;
    rsp_oh[grant_id] = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (gnt == IDW'(i)) begin
        sel_x = req_x[i*DATA_W +: DATA_W];
        sel_e = req_e[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    rsp_valid = '0;
    eng_ld    = 1'b0;
    busy      = (state != IDLE);
    eng_rst_n = ~rst;
    case (state)
      IDLE: begin
        if (hit) begin
          state_nxt = LOAD;
          if (!rst) req_ready = gnt_oh;
        end
      end
      LOAD: begin
        eng_ld    = 1'b1;
        state_nxt = RUN;
      end
      RUN: begin
        // A done arriving on the timeout cycle still wins over the abort.
        if (eng_done)                         state_nxt = RESP;
        else if (timer == TW'(TIMEOUT - 1))   state_nxt = ABORT;
      end
      ABORT: begin
        eng_rst_n = 1'b0;
        state_nxt = RESP;
      end
      RESP: begin
        rsp_valid = rsp_oh;
        if (rsp_ready[grant_id]) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operands are captured at grant and stay frozen until the job leaves RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      last     <= IDW'(N - 1);
      grant_id <= '0;
      op_x     <= '0;
      op_e     <= '0;
      timer    <= '0;
      rsp_y    <= '0;
      rsp_err  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (hit) begin
            grant_id <= gnt;
            op_x     <= sel_x;
            op_e     <= sel_e;
          end
        end
        LOAD: timer <= '0;
        RUN: begin
          timer <= timer + TW'(1);
          if (eng_done) begin
            rsp_y   <= eng_y;
            rsp_err <= 1'b0;
          end
        end
        ABORT: begin
          rsp_y   <= '0;
          rsp_err <= 1'b1;
        end
        RESP: begin
          if (rsp_ready[grant_id]) last <= grant_id;
        end
        default: ;
      endcase
    end
  end

  assign eng_x = op_x;
  assign eng_e = op_e;

endmodule

// File: tb/tb_pow_sched.sv
// Directed bench for pow_sched with a cycle-accurate pow32 engine stand-in
// (done 96 cycles after ld, result taken from the operands seen at done).
module tb_pow_sched;
  localparam int N       = 4;
  localparam int TIMEOUT = 128;

  logic          clk;
  logic          rst;
  logic [N-1:0]  req_valid;
  logic [N-1:0]  req_ready;
  logic [32*N-1:0] req_x;
  logic [32*N-1:0] req_e;
  logic [N-1:0]  rsp_valid;
  logic [N-1:0]  rsp_ready;
  logic [31:0]   rsp_y;
  logic          rsp_err;
  logic          busy;
  logic [1:0]    grant_id;
  logic          eng_rst_n;
  logic          eng_ld;
  logic [31:0]   eng_x;
  logic [31:0]   eng_e;
  logic          eng_done;
  logic [31:0]   eng_y;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  pow_sched #(.N(N), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_e(req_e),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_y(rsp_y), .rsp_err(rsp_err),
    .busy(busy), .grant_id(grant_id),
    .eng_rst_n(eng_rst_n), .eng_ld(eng_ld),
    .eng_x(eng_x), .eng_e(eng_e),
    .eng_done(eng_done), .eng_y(eng_y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Engine stand-in
  logic eng_dis = 1'b0;
  logic eng_act = 1'b0;
  int   eng_cnt = 0;

  function automatic logic [31:0] pow32(input logic [31:0] x, input logic [31:0] e);
    logic [31:0] r = 32'd1;
    logic [31:0] b = x;
    for (int i = 0; i < 32; i++) begin
      if (e[i]) r = r * b;
      b = b * b;
    end
    return r;
  endfunction

  initial begin
    eng_done = 1'b0;
    eng_y    = '0;
  end

  always @(negedge clk) begin
    eng_done = 1'b0;
    if (!eng_rst_n) begin
      eng_act = 1'b0;
      eng_cnt = 0;
    end else if (eng_ld) begin
      eng_act = 1'b1;
      eng_cnt = 96;
    end else if (eng_act) begin
      eng_cnt--;
      if (eng_cnt == 0) begin
        eng_act = 1'b0;
        if (!eng_dis) begin
          eng_done = 1'b1;
          eng_y    = pow32(eng_x, eng_e);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout sim did not finish");
    $fatal(1);
  end

  task automatic set_job(input int id, input logic [31:0] x, input logic [31:0] e);
    req_x[id*32 +: 32] = x;
    req_e[id*32 +: 32] = e;
    req_valid[id] = 1'b1;
  endtask

  task automatic wait_rsp(input int max, output int n);
    n = 0;
    while (rsp_valid == '0 && n < max) begin
      @(negedge clk);
      n++;
    end
    if (rsp_valid == '0) n = -1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = '1;
    rsp_ready = '1;
    req_x = '1;
    req_e = '1;
    @(negedge clk);
    @(negedge clk);
    chk_cnt++; if (req_ready !== 4'b0000) $display("FAIL rst_req_ready got=%b exp=0000", req_ready); else pass_cnt++;
    chk_cnt++; if (rsp_valid !== 4'b0000) $display("FAIL rst_rsp_valid got=%b exp=0000", rsp_valid); else pass_cnt++;
    chk_cnt++; if ({rsp_err, rsp_y} !== 33'd0) $display("FAIL rst_rsp got=%b/%h exp=0/0", rsp_err, rsp_y); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL rst_busy got=%b exp=0", busy); else pass_cnt++;
    chk_cnt++; if (grant_id !== 2'd0) $display("FAIL rst_grant_id got=%0d exp=0", grant_id); else pass_cnt++;
    chk_cnt++; if (eng_ld !== 1'b0) $display("FAIL rst_eng_ld got=%b exp=0", eng_ld); else pass_cnt++;
    chk_cnt++; if ({eng_x, eng_e} !== 64'd0) $display("FAIL rst_eng_ops got=%h/%h exp=0/0", eng_x, eng_e); else pass_cnt++;
    chk_cnt++; if (eng_rst_n !== 1'b0) $display("FAIL rst_eng_rst_n got=%b exp=0", eng_rst_n); else pass_cnt++;
    rst = 1'b0;
    req_valid = '0;
    req_x = '0;
    req_e = '0;
    @(negedge clk);
    chk_cnt++; if (eng_rst_n !== 1'b1) $display("FAIL rel_eng_rst_n got=%b exp=1", eng_rst_n); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL rel_busy got=%b exp=0", busy); else pass_cnt++;
  endtask

  task automatic test_single();
    int n;
    set_job(0, 32'd3, 32'd5);
    #1;
    chk_cnt++; if (req_ready !== 4'b0001) $display("FAIL single_req_ready got=%b exp=0001", req_ready); else pass_cnt++;
    @(negedge clk);
    req_valid = '0;
    chk_cnt++; if (eng_ld !== 1'b1) $display("FAIL single_ld got=%b exp=1", eng_ld); else pass_cnt++;
    chk_cnt++; if ({eng_x, eng_e} !== {32'd3, 32'd5}) $display("FAIL single_ops got=%h/%h exp=3/5", eng_x, eng_e); else pass_cnt++;
    chk_cnt++; if (req_ready !== 4'b0000) $display("FAIL single_ready_load got=%b exp=0000", req_ready); else pass_cnt++;
    @(negedge clk);
    chk_cnt++; if (eng_ld !== 1'b0) $display("FAIL single_ld_once got=%b exp=0", eng_ld); else pass_cnt++;
    wait_rsp(200, n);
    chk_cnt++; if (n !== 96) $display("FAIL single_latency got=%0d exp=96", n); else pass_cnt++;
    chk_cnt++; if (rsp_valid !== 4'b0001) $display("FAIL single_rsp_valid got=%b exp=0001", rsp_valid); else pass_cnt++;
    chk_cnt++; if ({rsp_err, rsp_y} !== {1'b0, 32'd243}) $display("FAIL single_rsp got=%b/%0d exp=0/243", rsp_err, rsp_y); else pass_cnt++;
    @(negedge clk);
    chk_cnt++; if (busy !== 1'b0) $display("FAIL single_idle_busy got=%b exp=0", busy); else pass_cnt++;
  endtask

  task automatic test_edge_operands();
    logic [31:0] tx [3] = '{32'd7, 32'h0001_0000, 32'hFFFF_FFFF};
    logic [31:0] te [3] = '{32'd0, 32'd2, 32'd3};
    logic [31:0] ty [3] = '{32'd1, 32'd0, 32'hFFFF_FFFF};
    int n;
    for (int k = 0; k < 3; k++) begin
      set_job(0, tx[k], te[k]);
      @(negedge clk);
      req_valid = '0;
      wait_rsp(200, n);
      chk_cnt++; if (n !== 97) $display("FAIL edge%0d_latency got=%0d exp=97", k, n); else pass_cnt++;
      chk_cnt++; if (rsp_valid !== 4'b0001) $display("FAIL edge%0d_rsp_valid got=%b exp=0001", k, rsp_valid); else pass_cnt++;
      chk_cnt++; if ({rsp_err, rsp_y} !== {1'b0, ty[k]}) $display("FAIL edge%0d_rsp got=%b/%h exp=0/%h", k, rsp_err, rsp_y, ty[k]); else pass_cnt++;
      @(negedge clk);
    end
  endtask

  task automatic test_fairness();
    logic [31:0] ty [4] = '{32'd8, 32'd27, 32'd64, 32'd125};
    logic [3:0] oh;
    int g, n;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < N; i++) set_job(i, 32'(i + 2), 32'd3);
    for (int j = 0; j < 5; j++) begin
      g  = j % N;
      oh = 4'(1 << g);
      #1;
      chk_cnt++; if (req_ready !== oh) $display("FAIL fair%0d_req_ready got=%b exp=%b", j, req_ready, oh); else pass_cnt++;
      @(negedge clk);
      chk_cnt++; if (grant_id !== 2'(g)) $display("FAIL fair%0d_grant got=%0d exp=%0d", j, grant_id, g); else pass_cnt++;
      wait_rsp(200, n);
      chk_cnt++; if (rsp_valid !== oh) $display("FAIL fair%0d_rsp_valid got=%b exp=%b", j, rsp_valid, oh); else pass_cnt++;
      chk_cnt++; if (rsp_y !== ty[g]) $display("FAIL fair%0d_rsp_y got=%0d exp=%0d", j, rsp_y, ty[g]); else pass_cnt++;
      @(negedge clk);
    end
    req_valid = '0;
  endtask

  task automatic test_backpressure();
    int n;
    rsp_ready = 4'b1101;
    set_job(1, 32'd5, 32'd2);
    set_job(2, 32'd3, 32'd3);
    #1;
    chk_cnt++; if (req_ready !== 4'b0010) $display("FAIL bp_req_ready got=%b exp=0010", req_ready); else pass_cnt++;
    @(negedge clk);
    req_valid[1] = 1'b0;
    wait_rsp(200, n);
    chk_cnt++; if (n !== 97) $display("FAIL bp_latency got=%0d exp=97", n); else pass_cnt++;
    for (int i = 0; i < 10; i++) begin
      chk_cnt++;
      if ({rsp_valid, rsp_y, rsp_err, busy, req_ready} !== {4'b0010, 32'd25, 1'b0, 1'b1, 4'b0000})
        $display("FAIL bp_hold%0d got=%b/%0d/%b/%b/%b exp=0010/25/0/1/0000", i, rsp_valid, rsp_y, rsp_err, busy, req_ready);
      else pass_cnt++;
      @(negedge clk);
    end
    rsp_ready = 4'b0010;
    @(negedge clk);
    chk_cnt++; if (req_ready !== 4'b0100) $display("FAIL bp_accept got=%b exp=0100", req_ready); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL bp_idle_busy got=%b exp=0", busy); else pass_cnt++;
    @(negedge clk);
    req_valid = '0;
    rsp_ready = '1;
    wait_rsp(200, n);
    chk_cnt++; if (rsp_valid !== 4'b0100) $display("FAIL bp_next_rsp_valid got=%b exp=0100", rsp_valid); else pass_cnt++;
    chk_cnt++; if (rsp_y !== 32'd27) $display("FAIL bp_next_rsp_y got=%0d exp=27", rsp_y); else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_watchdog();
    int n;
    eng_dis = 1'b1;
    set_job(0, 32'd9, 32'd9);
    #1;
    chk_cnt++; if (req_ready !== 4'b0001) $display("FAIL wd_req_ready got=%b exp=0001", req_ready); else pass_cnt++;
    @(negedge clk);
    req_valid = '0;
    n = 0;
    while (eng_rst_n === 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk_cnt++; if (n !== TIMEOUT + 1) $display("FAIL wd_abort_time got=%0d exp=%0d", n, TIMEOUT + 1); else pass_cnt++;
    chk_cnt++; if ({rsp_valid, busy} !== {4'b0000, 1'b1}) $display("FAIL wd_abort_state got=%b/%b exp=0000/1", rsp_valid, busy); else pass_cnt++;
    @(negedge clk);
    chk_cnt++; if (eng_rst_n !== 1'b1) $display("FAIL wd_rst_pulse got=%b exp=1", eng_rst_n); else pass_cnt++;
    chk_cnt++; if (rsp_valid !== 4'b0001) $display("FAIL wd_rsp_valid got=%b exp=0001", rsp_valid); else pass_cnt++;
    chk_cnt++; if ({rsp_err, rsp_y} !== {1'b1, 32'd0}) $display("FAIL wd_rsp got=%b/%h exp=1/0", rsp_err, rsp_y); else pass_cnt++;
    @(negedge clk);
    eng_dis = 1'b0;
    set_job(0, 32'd2, 32'd10);
    @(negedge clk);
    req_valid = '0;
    wait_rsp(200, n);
    chk_cnt++; if (n !== 97) $display("FAIL wd_next_latency got=%0d exp=97", n); else pass_cnt++;
    chk_cnt++; if ({rsp_err, rsp_y} !== {1'b0, 32'd1024}) $display("FAIL wd_next_rsp got=%b/%0d exp=0/1024", rsp_err, rsp_y); else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_run();
    int n;
    logic seen;
    set_job(3, 32'd3, 32'd4);
    @(negedge clk);
    req_valid = '0;
    chk_cnt++; if (grant_id !== 2'd3) $display("FAIL mid_grant got=%0d exp=3", grant_id); else pass_cnt++;
    repeat (50) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_cnt++; if ({busy, eng_rst_n, eng_ld} !== 3'b000) $display("FAIL mid_ctrl got=%b%b%b exp=000", busy, eng_rst_n, eng_ld); else pass_cnt++;
    chk_cnt++; if ({eng_x, eng_e} !== 64'd0) $display("FAIL mid_ops got=%h/%h exp=0/0", eng_x, eng_e); else pass_cnt++;
    chk_cnt++; if ({rsp_valid, rsp_err, rsp_y, grant_id} !== 39'd0) $display("FAIL mid_rsp got=%b/%b/%h/%0d exp=0", rsp_valid, rsp_err, rsp_y, grant_id); else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (rsp_valid != '0 || busy) seen = 1'b1;
    end
    chk_cnt++; if (seen !== 1'b0) $display("FAIL mid_dropped got=%b exp=0", seen); else pass_cnt++;
    set_job(0, 32'd2, 32'd5);
    #1;
    chk_cnt++; if (req_ready !== 4'b0001) $display("FAIL mid_next_ready got=%b exp=0001", req_ready); else pass_cnt++;
    @(negedge clk);
    req_valid = '0;
    wait_rsp(200, n);
    chk_cnt++; if (n !== 97) $display("FAIL mid_next_latency got=%0d exp=97", n); else pass_cnt++;
    chk_cnt++; if ({rsp_valid, rsp_err, rsp_y} !== {4'b0001, 1'b0, 32'd32}) $display("FAIL mid_next_rsp got=%b/%b/%0d exp=0001/0/32", rsp_valid, rsp_err, rsp_y); else pass_cnt++;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single();
    test_edge_operands();
    test_fairness();
    test_backpressure();
    test_watchdog();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/pow_sched.md
# pow_sched

Round-robin scheduler that shares one 32-bit exponentiation engine (the `pow32` square-and-multiply core) among N requesters. The block accepts (x, e) jobs over per-requester valid/ready handshakes and drives the engine's `ld`/`x`/`e`. It holds the operands stable for the whole run, captures `y` on `done`, and returns the result to the granted requester. A watchdog aborts a run that never completes and resets the engine.

## Interface

Parameters:

- N, 4, number of requesters (2..8)
- TIMEOUT, 128, maximum RUN cycles allowed before abort (must be > 96)

Ports:

- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req_valid  in  N  job request per requester
- req_ready  out  N  one-hot accept pulse
- req_x  in  32*N  base; requester i uses bits [32i+31:32i]
- req_e  in  32*N  exponent, same packing
- rsp_valid  out  N  one-hot result valid
- rsp_ready  in  N  result accepted
- rsp_y  out  32  result for the requester flagged in rsp_valid
- rsp_err  out  1  qualifies rsp_y; 1 = job aborted by watchdog, rsp_y = 0
- busy  out  1  high in every state except IDLE
- grant_id  out  clog2(N)  index of current/last granted requester
- eng_rst_n  out  1  engine reset, active-low
- eng_ld  out  1  engine load strobe
- eng_x  out  32  engine base
- eng_e  out  32  engine exponent
- eng_done  in  1  engine done pulse
- eng_y  in  32  engine result

## Operation

Reset values:

- req_ready = 0, rsp_valid = 0, rsp_y = 0, rsp_err = 0, busy = 0, grant_id = 0.
- eng_ld = 0, eng_x = 0, eng_e = 0, eng_rst_n = 0 (eng_rst_n = ~rst except during ABORT).
- Round-robin pointer last = N-1, so requester 0 has first priority.

States are IDLE, LOAD, RUN, ABORT and RESP.

- **IDLE:**
  - Search req_valid starting at last+1 mod N, wrapping.
  - On first hit g: req_ready[g] = 1 for this cycle (combinational from req_valid and pointer).
  - Latch req_x[g] and req_e[g] into operand registers, grant_id = g, go to LOAD.
  - If no req_valid is set, stay in IDLE.
- **LOAD:** eng_ld = 1 for exactly one cycle; clear the watchdog timer; go to RUN.
- **RUN:**
  - eng_x and eng_e stay equal to the latched operands. The engine reads x on every multiply step, so the operands must not change until the job leaves RUN.
  - Timer increments each cycle.
  - eng_done = 1: rsp_y = eng_y, rsp_err = 0, go to RESP.
  - Else if timer == TIMEOUT-1: go to ABORT.
- **ABORT:** eng_rst_n = 0 for one cycle; rsp_y = 0, rsp_err = 1; go to RESP.
- **RESP:**
  - rsp_valid[grant_id] = 1; rsp_y and rsp_err are held.
  - On rsp_ready[grant_id]: last = grant_id, rsp_valid clears, go to IDLE.
  - rsp_ready bits of other requesters are ignored.

Boundary rules:

- eng_done outside RUN is ignored.
- eng_done in the same cycle as the timeout compare counts as a completion, not an abort.
- req_valid is ignored outside IDLE, and req_ready is 0 outside IDLE.
- A requester may hold req_valid while its own response is pending; it is re-arbitrated only in the next IDLE.
- rst in any state returns everything to the reset values on the next edge. It drops any in-flight job with no response, and eng_rst_n = 0 resets the engine.
- Arithmetic is the engine's modulo 2^32; the scheduler never modifies data.

## Timing

- Accept at cycle a (IDLE), eng_ld at a+1 (LOAD), RUN from a+2.
- A conforming engine raises eng_done at a+97: 32 iterations × 3 cycles after ld.
- rsp_valid is first high at a+98.
- With rsp_ready held at 1, the scheduler is back in IDLE at a+99 and the next accept occurs at a+99.
- Minimum job-to-job spacing is 99 cycles.
- Abort path: ABORT at a+2+TIMEOUT, rsp_valid at a+3+TIMEOUT.
- Response persists indefinitely under backpressure; busy stays 1.

## Test plan

- **Single job:** req_valid[0] with x=3, e=5. Required: req_ready[0] pulse, eng_ld one cycle later, rsp_valid[0] 97 cycles after eng_ld, rsp_y=243, rsp_err=0.
- **Edge operands:**
  - x=7, e=0 → rsp_y=1.
  - x=0x00010000, e=2 → rsp_y=0 (wrap).
  - x=0xFFFFFFFF, e=3 → rsp_y=0xFFFFFFFF.
- **Fairness:** all four req_valid held high for 5 jobs. Grants are 0,1,2,3,0, and each result is routed to the matching rsp_valid bit.
- **Backpressure:** rsp_ready low for 10 cycles in RESP. Required: rsp_y, rsp_valid and busy stable, no req_ready, and accept occurs on the cycle after rsp_ready rises.
- **Watchdog:** eng_done tied 0. Required: ABORT after TIMEOUT RUN cycles, eng_rst_n low exactly one cycle, rsp_err=1, rsp_y=0. A following job (x=2, e=10) returns 1024.
- **Reset mid-RUN:** assert rst 50 cycles after eng_ld. Required: all outputs at reset values, no rsp_valid for the dropped job, and the next job completes normally.
